// File: rtl/pe_noc_map_ctrl.sv
// Runtime address-map controller for the PE NoC crossbar: shadow/active windows, commit quiesce/drain/swap,
// and per-cluster outstanding-transaction throttling with AXI-safe registered stall outputs.
module pe_noc_map_ctrl #(
  parameter int NumClusters    = 4,
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 128,
  parameter int DrainTimeout   = 4096
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        cfg_we_i,
  input  logic [$clog2(NumClusters+2)-1:0]            cfg_idx_i,
  input  logic                                        cfg_sel_end_i,
  input  logic [AddrWidth-1:0]                        cfg_wdata_i,
  output logic                                        cfg_ready_o,
  input  logic                                        commit_i,
  output logic                                        busy_o,
  output logic                                        commit_done_o,
  output logic                                        commit_err_o,
  output logic                                        map_valid_o,
  output logic [NumClusters+1:0][AddrWidth-1:0]       start_addr_o,
  output logic [NumClusters+1:0][AddrWidth-1:0]       end_addr_o,
  input  logic [NumClusters-1:0]                      aw_valid_i,
  input  logic [NumClusters-1:0]                      aw_ready_i,
  input  logic [NumClusters-1:0]                      b_valid_i,
  input  logic [NumClusters-1:0]                      b_ready_i,
  input  logic [NumClusters-1:0]                      ar_valid_i,
  input  logic [NumClusters-1:0]                      ar_ready_i,
  input  logic [NumClusters-1:0]                      r_valid_i,
  input  logic [NumClusters-1:0]                      r_ready_i,
  input  logic [NumClusters-1:0]                      r_last_i,
  output logic [NumClusters-1:0]                      aw_stall_o,
  output logic [NumClusters-1:0]                      ar_stall_o
);

  localparam int NumEntries = NumClusters + 2;
  localparam int IdxW       = $clog2(NumEntries);
  localparam int CntW       = $clog2(MaxOutstanding + 1);
  localparam int TmrW       = $clog2(DrainTimeout);

  typedef enum logic [2:0] {ST_IDLE, ST_QUIESCE, ST_DRAIN, ST_SWAP, ST_RELEASE} state_t;

  state_t                                 state_q, state_d;
  logic [TmrW-1:0]                        timer_q, timer_d;
  logic                                   done_d, err_d;
  logic                                   busy_q, done_q, err_q, valid_q, cfg_ready_q;
  logic [NumEntries-1:0][AddrWidth-1:0]   sh_start_q, sh_start_d, sh_end_q, sh_end_d;
  logic [NumEntries-1:0][AddrWidth-1:0]   act_start_q, act_end_q;
  logic [NumClusters-1:0][CntW-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [NumClusters-1:0]                 aw_stall_q, aw_stall_d, ar_stall_q, ar_stall_d;
  logic [NumClusters-1:0]                 aw_hs, b_hs, ar_hs, r_hs, aw_thr, ar_thr;
  logic                                   quiesce, all_zero;

  assign aw_hs = aw_valid_i & aw_ready_i;
  assign b_hs  = b_valid_i & b_ready_i;
  assign ar_hs = ar_valid_i & ar_ready_i;
  assign r_hs  = r_valid_i & r_ready_i & r_last_i;

  function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] c, input logic inc, input logic dec);
    logic [CntW-1:0] n;
    n = c;
    if (inc && !dec)                n = c + CntW'(1);
    else if (dec && !inc && c != '0) n = c - CntW'(1);
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (commit_i) begin
        state_d = ST_QUIESCE;
        timer_d = '0;
      end
      ST_QUIESCE, ST_DRAIN: begin
        timer_d = timer_q + TmrW'(1);
        if (timer_d == TmrW'(DrainTimeout - 1)) begin
          state_d = ST_RELEASE;
          err_d   = 1'b1;
        end else if (state_q == ST_QUIESCE && (&{aw_stall_q, ar_stall_q})) begin
          state_d = ST_DRAIN;
        end else if (state_q == ST_DRAIN && all_zero) begin
          state_d = ST_SWAP;
          done_d  = 1'b1;
        end
      end
      ST_SWAP:    state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Quiesce keys off the next state so the stall flops are already high in the first QUIESCE cycle.
  assign quiesce  = (state_d == ST_QUIESCE) || (state_d == ST_DRAIN) || (state_d == ST_SWAP);
  assign all_zero = (wr_cnt_q == '0) && (rd_cnt_q == '0);

  always_comb begin
    for (int i = 0; i < NumClusters; i++) begin
      wr_cnt_d[i] = cnt_next(wr_cnt_q[i], aw_hs[i], b_hs[i]);
      rd_cnt_d[i] = cnt_next(rd_cnt_q[i], ar_hs[i], r_hs[i]);
      aw_thr[i]   = ({1'b0, wr_cnt_q[i]} + {{CntW{1'b0}}, aw_hs[i]}) >= (CntW+1)'(MaxOutstanding);
      ar_thr[i]   = ({1'b0, rd_cnt_q[i]} + {{CntW{1'b0}}, ar_hs[i]}) >= (CntW+1)'(MaxOutstanding);
      // A stall may only assert while no request is pending on the channel.
      aw_stall_d[i] = (aw_thr[i] | quiesce) & (aw_stall_q[i] | ~aw_valid_i[i] | aw_hs[i]);
      ar_stall_d[i] = (ar_thr[i] | quiesce) & (ar_stall_q[i] | ~ar_valid_i[i] | ar_hs[i]);
    end
  end

  always_comb begin
    sh_start_d = sh_start_q;
    sh_end_d   = sh_end_q;
    if (cfg_we_i && cfg_ready_q && ({1'b0, cfg_idx_i} < (IdxW+1)'(NumEntries))) begin
      if (cfg_sel_end_i) sh_end_d[cfg_idx_i]   = cfg_wdata_i;
      else               sh_start_d[cfg_idx_i] = cfg_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
      sh_start_q  <= '0;
      sh_end_q    <= '0;
      act_start_q <= '0;
      act_end_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      aw_stall_q  <= '0;
      ar_stall_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      busy_q      <= (state_d != ST_IDLE);
      cfg_ready_q <= (state_d == ST_IDLE);
      done_q      <= done_d;
      err_q       <= err_d;
      sh_start_q  <= sh_start_d;
      sh_end_q    <= sh_end_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      aw_stall_q  <= aw_stall_d;
      ar_stall_q  <= ar_stall_d;
      if (done_d) begin
        act_start_q <= sh_start_q;
        act_end_q   <= sh_end_q;
        valid_q     <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NumClusters; g++) begin : g_underflow
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs[g] && !aw_hs[g] && wr_cnt_q[g] == '0));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_hs[g] && !ar_hs[g] && rd_cnt_q[g] == '0));
  end

  assign cfg_ready_o   = cfg_ready_q;
  assign busy_o        = busy_q;
  assign commit_done_o = done_q;
  assign commit_err_o  = err_q;
  assign map_valid_o   = valid_q;
  assign start_addr_o  = act_start_q;
  assign end_addr_o    = act_end_q;
  assign aw_stall_o    = aw_stall_q;
  assign ar_stall_o    = ar_stall_q;

endmodule
